// File: rtl/parallel_to_serial.sv
// parallel_to_serial
// Serializer stage that feeds the serial_to_parallel deserializer. Words of
// `width` bits arrive on a valid/ready handshake and leave one bit per cycle
// on a serial_valid/serial_ready stream. A one-word holding register lets the
// next word be taken while the current one is still shifting, so consecutive
// words stream out with no idle cycle between them.
//
// Parameters:
//   width      bits per word (>= 2)
//   msb_first  0 = bit 0 sent first, 1 = bit width-1 sent first
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   parallel_valid  upstream word available
//   parallel_data   upstream word
//   parallel_ready  a word can be accepted this cycle (registered only)
//   serial_ready    downstream accepts the current bit
//   serial_valid    serial_data is valid this cycle
//   serial_data     current bit
//   serial_last     current bit is the final bit of its word
//   busy            shifter or holding register occupied
module parallel_to_serial #(
  parameter int width     = 8,
  parameter int msb_first = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  input  logic             serial_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  output logic             busy
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [width-1:0] shifter;
  logic [width-1:0] hold_reg;
  logic             hold_full;
  logic [CW-1:0]    bit_cnt;

  logic accept;
  logic xfer;
  logic last_xfer;

  // Ready depends only on the holding register, so the upstream never sees a
  // combinational path from serial_ready.
  assign parallel_ready = !hold_full;
  assign accept         = parallel_valid && !hold_full;

  assign serial_valid = (state == SHIFT);
  assign serial_last  = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign serial_data  = (state == SHIFT)
                        ? ((msb_first != 0) ? shifter[width-1] : shifter[0])
                        : 1'b0;
  assign busy         = (state == SHIFT) || hold_full;

  assign xfer      = serial_valid && serial_ready;
  assign last_xfer = xfer && (bit_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shifter   <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shifter <= parallel_data;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        default: begin
          if (last_xfer) begin
            // End of word: the held word has priority, then a word offered
            // this very edge, so back-to-back words never leave a bubble.
            bit_cnt <= '0;
            if (hold_full) begin
              shifter   <= hold_reg;
              hold_full <= 1'b0;
            end else if (accept) begin
              shifter <= parallel_data;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (xfer) begin
              if (msb_first != 0) begin
                shifter <= {shifter[width-2:0], 1'b0};
              end else begin
                shifter <= {1'b0, shifter[width-1:1]};
              end
              bit_cnt <= bit_cnt + CW'(1);
            end
            if (accept) begin
              hold_reg  <= parallel_data;
              hold_full <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial
// Drives two serializers (LSB-first and MSB-first) with the same word stream
// and compares every cycle against a queue-based model of the words held in
// the block. Two small receivers rebuild words from each serial stream and
// compare them with the words the model says were accepted.
module tb_parallel_to_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         parallel_valid;
  logic [W-1:0] parallel_data;
  logic         serial_ready;

  logic ready0, sv0, sd0, sl0, busy0;
  logic ready1, sv1, sd1, sl1, busy1;

  int checks = 0;
  int errors = 0;

  // Model: words inside the block, head is the one on the wire.
  logic [W-1:0] word_q[$];
  int           bit_pos = 0;

  // Receivers: expected words and partial reassembly per stream.
  logic [W-1:0] rx_exp0[$];
  logic [W-1:0] rx_exp1[$];
  logic [W-1:0] rx_word0, rx_word1;
  int           rx_cnt0 = 0;
  int           rx_cnt1 = 0;

  parallel_to_serial #(.width(W), .msb_first(0)) u_lsb (
    .clk(clk), .rst(rst),
    .parallel_valid(parallel_valid), .parallel_data(parallel_data),
    .parallel_ready(ready0), .serial_ready(serial_ready),
    .serial_valid(sv0), .serial_data(sd0), .serial_last(sl0), .busy(busy0)
  );

  parallel_to_serial #(.width(W), .msb_first(1)) u_msb (
    .clk(clk), .rst(rst),
    .parallel_valid(parallel_valid), .parallel_data(parallel_data),
    .parallel_ready(ready1), .serial_ready(serial_ready),
    .serial_valid(sv1), .serial_data(sd1), .serial_last(sl1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    word_q.delete();
    rx_exp0.delete();
    rx_exp1.delete();
    bit_pos = 0;
    rx_cnt0 = 0;
    rx_cnt1 = 0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_valid_lsb", {31'd0, sv0}, 0);
    checkOutput("rst_data_lsb",  {31'd0, sd0}, 0);
    checkOutput("rst_last_lsb",  {31'd0, sl0}, 0);
    checkOutput("rst_busy_lsb",  {31'd0, busy0}, 0);
    checkOutput("rst_ready_lsb", {31'd0, ready0}, 1);
    checkOutput("rst_valid_msb", {31'd0, sv1}, 0);
    checkOutput("rst_busy_msb",  {31'd0, busy1}, 0);
    checkOutput("rst_ready_msb", {31'd0, ready1}, 1);
  endtask

  // One clock cycle: check outputs against the model, drive new inputs,
  // then advance the model by what the coming rising edge will do.
  task automatic applyStimulus(input logic pv, input logic [W-1:0] pd,
                               input logic sr);
    logic         ev;
    logic         er;
    logic [W-1:0] head;
    @(negedge clk);
    ev   = (word_q.size() > 0);
    er   = (word_q.size() < 2);
    head = ev ? word_q[0] : '0;
    checkOutput("valid_lsb", {31'd0, sv0}, {31'd0, ev});
    checkOutput("valid_msb", {31'd0, sv1}, {31'd0, ev});
    checkOutput("data_lsb",  {31'd0, sd0}, {31'd0, ev && head[bit_pos]});
    checkOutput("data_msb",  {31'd0, sd1}, {31'd0, ev && head[W-1-bit_pos]});
    checkOutput("last_lsb",  {31'd0, sl0}, {31'd0, ev && (bit_pos == W-1)});
    checkOutput("last_msb",  {31'd0, sl1}, {31'd0, ev && (bit_pos == W-1)});
    checkOutput("ready_lsb", {31'd0, ready0}, {31'd0, er});
    checkOutput("ready_msb", {31'd0, ready1}, {31'd0, er});
    checkOutput("busy_lsb",  {31'd0, busy0}, {31'd0, ev});
    checkOutput("busy_msb",  {31'd0, busy1}, {31'd0, ev});

    parallel_valid = pv;
    parallel_data  = pd;
    serial_ready   = sr;

    // Receivers rebuild words purely from what each DUT puts on the wire.
    if (sv0 && sr) begin
      rx_word0[rx_cnt0] = sd0;
      rx_cnt0++;
      if (rx_cnt0 == W) begin
        rx_cnt0 = 0;
        if (rx_exp0.size() == 0) checkOutput("rx_extra_lsb", {24'd0, rx_word0}, 32'hFFFF_FFFF);
        else checkOutput("rx_word_lsb", {24'd0, rx_word0}, {24'd0, rx_exp0.pop_front()});
      end
    end
    if (sv1 && sr) begin
      rx_word1[W-1-rx_cnt1] = sd1;
      rx_cnt1++;
      if (rx_cnt1 == W) begin
        rx_cnt1 = 0;
        if (rx_exp1.size() == 0) checkOutput("rx_extra_msb", {24'd0, rx_word1}, 32'hFFFF_FFFF);
        else checkOutput("rx_word_msb", {24'd0, rx_word1}, {24'd0, rx_exp1.pop_front()});
      end
    end

    if (ev && sr) begin
      bit_pos++;
      if (bit_pos == W) begin
        void'(word_q.pop_front());
        bit_pos = 0;
      end
    end
    if (pv && er) begin
      word_q.push_back(pd);
      rx_exp0.push_back(pd);
      rx_exp1.push_back(pd);
    end
  endtask

  task automatic idleCycles(input int n, input logic sr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, W'($urandom), sr);
  endtask

  initial begin
    rst            = 1'b0;
    parallel_valid = 1'b0;
    parallel_data  = '0;
    serial_ready   = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues();
    rst = 1'b1;

    // Single word, both bit orders.
    $display("[TB] single word A5 / 01");
    applyStimulus(1'b1, 8'hA5, 1'b1);
    idleCycles(11, 1'b1);
    applyStimulus(1'b1, 8'h01, 1'b1);
    idleCycles(11, 1'b1);

    // Back-to-back: second word offered while the first is shifting.
    $display("[TB] back-to-back FF then 00");
    applyStimulus(1'b1, 8'hFF, 1'b1);
    idleCycles(3, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1);
    idleCycles(20, 1'b1);

    // Valid held high continuously: holding register full, ready low.
    $display("[TB] continuous offer");
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, W'($urandom), 1'b1);
    idleCycles(20, 1'b1);

    // Backpressure after three bits.
    $display("[TB] backpressure C3");
    applyStimulus(1'b1, 8'hC3, 1'b1);
    idleCycles(3, 1'b1);
    idleCycles(4, 1'b0);
    idleCycles(10, 1'b1);

    // Reset mid-word with a word held.
    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 8'h5A, 1'b1);
    applyStimulus(1'b1, 8'h96, 1'b1);
    idleCycles(3, 1'b1);
    parallel_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkResetValues();
    clearModel();
    @(negedge clk);
    checkResetValues();
    rst = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b1);
    idleCycles(11, 1'b1);

    // Random traffic with random backpressure.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), W'($urandom),
                    ($urandom_range(0, 4) != 0));
    end
    idleCycles(40, 1'b1);

    checkOutput("drain_lsb", rx_exp0.size(), 0);
    checkOutput("drain_msb", rx_exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
